diff_commit_unit: RTL and testbench
===================================

Name: diff_commit_unit

Overview:
- Multi-channel difftest commit and trap monitor for the next core generation, which retires up to COMMIT_W instructions per cycle.
- Sits between the core's retire stage and the DifftestInstrCommit / DifftestTrapEvent instances.
- Registers retirements, orders and filters them, counts cycles and instructions, detects the trap instruction, and adds a no-commit watchdog.

Parameters:
- COMMIT_W, 2, number of retire channels (1..4)
- XLEN, 64, data/PC width
- TRAP_OPCODE, 7'h6b, opcode field that marks the halt/trap instruction
- TIMEOUT, 5000, cycles without any accepted commit before a forced trap; 0 disables the watchdog
- TIMEOUT_CODE, 8'hFF, trap_code reported on watchdog trap

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  COMMIT_W  per-channel retire valid
- in_pc  in  COMMIT_W*XLEN  retired PC, channel i at [i*XLEN +: XLEN]
- in_inst  in  COMMIT_W*32  retired instruction word
- in_wen  in  COMMIT_W  register write enable
- in_wdest  in  COMMIT_W*5  destination register index
- in_wdata  in  COMMIT_W*XLEN  write data
- in_skip  in  COMMIT_W  skip compare (putch/CSR)
- a0_data  in  XLEN  current x10 value, sampled for the trap code
- cmt_valid  out  COMMIT_W  registered commit valid
- cmt_pc  out  COMMIT_W*XLEN  registered PC
- cmt_inst  out  COMMIT_W*32  registered instruction
- cmt_wen  out  COMMIT_W  registered write enable
- cmt_wdest  out  COMMIT_W*8  destination, zero-extended to 8 bits
- cmt_wdata  out  COMMIT_W*XLEN  registered write data
- cmt_skip  out  COMMIT_W  registered skip
- trap_valid  out  1  trap event; stays high once set
- trap_code  out  8  trap code
- trap_pc  out  XLEN  PC of the trapping instruction
- cycle_cnt  out  64  cycles since reset
- instr_cnt  out  64  accepted instructions since reset
- halted  out  1  monitor frozen

Behaviour:
- Reset (rst=1 at posedge clk): every output and internal register clears to 0, including the watchdog counter. Reset always wins, including while halted.
- All capture happens on posedge clk with 1-cycle latency: inputs sampled at edge N appear on cmt_* after edge N.

Channel acceptance (per edge, not halted):
- Channel i is accepted iff in_valid[i]=1 and every lower channel is accepted.
- Valid is contiguous from channel 0. A gap drops all higher channels; they are not counted and cmt_valid is 0 for them.
- A channel is suppressed (not accepted) if a lower accepted channel in the same cycle is a trap instruction.
- For an accepted channel: cmt_* carry its data.
- If in_wdest==0, cmt_wen is forced to 0.
- For non-accepted channels, cmt_valid=0 and all other cmt_* fields for that channel are 0.

Counters:
- cycle_cnt increments by 1 every edge while halted=0.
- instr_cnt increments by the number of accepted channels (0..COMMIT_W) while halted=0.
- Both are 64-bit and wrap modulo 2^64.

Trap detection:
- Trigger: the lowest accepted channel with in_inst[6:0]==TRAP_OPCODE. That channel itself is committed and counted.
- At the same edge: trap_valid<=1, halted<=1, trap_code<=a0_data[7:0], trap_pc<=that channel's PC.

Watchdog:
- A counter clears on any edge with at least one accepted channel and otherwise increments.
- When the counter reaches TIMEOUT-1 with no accepted channel: trap_valid<=1, halted<=1, trap_code<=TIMEOUT_CODE, trap_pc<=the last accepted PC (0 if none).
- An instruction trap and a timeout at the same edge: the instruction trap wins.

Halted state:
- No further capture: cmt_valid<=0 for all channels.
- cycle_cnt, instr_cnt, trap_* and the watchdog all hold.
- Only rst exits the halted state.

State machine: RUN -> HALT, on a trap instruction or on timeout; HALT -> RUN only via rst.

Test Plan:
- Single-commit reset check: reset 2 cycles, then channel 0 valid with pc=0x80000000, inst=0x00100093 (addi x1,x0,1), wen=1, wdest=1, wdata=1 -> next cycle: cmt_valid=2'b01, cmt_wdest[7:0]=8'd1; instr_cnt=1, cycle_cnt=1.
- Dual commit: both channels valid for 3 cycles -> instr_cnt=6, cycle_cnt=3; channel 1 carries wdest=0 with wen=1 -> cmt_wen[1]=0.
- Gap: in_valid=2'b10 -> cmt_valid=2'b00, instr_cnt unchanged, watchdog counter increments.
- Trap in channel 0: inst[6:0]=7'h6b, a0_data=0, channel 1 also valid -> cmt_valid=2'b01, trap_valid=1, trap_code=0, trap_pc=channel-0 PC. Then 10 more cycles of valid input -> cmt_valid stays 0 and counters stay frozen.
- Watchdog: TIMEOUT=8, one commit at pc=0x80000010, then 8 idle cycles -> trap_valid rises on the 8th idle edge, trap_code=8'hFF, trap_pc=0x80000010. A commit on the 7th idle cycle prevents the trap instead.
- Reset while halted: assert rst one cycle -> all outputs 0, halted=0. A following commit is counted as instr_cnt=1.

Source files
------------

// File: rtl/diff_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : diff_commit_unit
// Purpose  : Multi-channel difftest commit and trap monitor. It registers up
//            to COMMIT_W retirements per cycle and orders and filters them.
//            It also counts cycles and instructions, detects the halt/trap
//            instruction and forces a trap when no commit arrives for
//            TIMEOUT cycles.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            in_*                   - per-channel retire bundle from the core
//            a0_data                - x10 value, low byte becomes trap_code
//            cmt_*                  - registered, filtered commit bundle
//            trap_valid/code/pc     - sticky trap event
//            cycle_cnt, instr_cnt   - 64-bit free-running counters
//            halted                 - monitor frozen after a trap
// Revision : 1.0 - initial release
// ============================================================================
module diff_commit_unit #(
    parameter int          COMMIT_W     = 2,
    parameter int          XLEN         = 64,
    parameter logic [6:0]  TRAP_OPCODE  = 7'h6b,
    parameter int          TIMEOUT      = 5000,
    parameter logic [7:0]  TIMEOUT_CODE = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COMMIT_W-1:0]      in_valid,
    input  logic [COMMIT_W*XLEN-1:0] in_pc,
    input  logic [COMMIT_W*32-1:0]   in_inst,
    input  logic [COMMIT_W-1:0]      in_wen,
    input  logic [COMMIT_W*5-1:0]    in_wdest,
    input  logic [COMMIT_W*XLEN-1:0] in_wdata,
    input  logic [COMMIT_W-1:0]      in_skip,
    input  logic [XLEN-1:0]          a0_data,
    output logic [COMMIT_W-1:0]      cmt_valid,
    output logic [COMMIT_W*XLEN-1:0] cmt_pc,
    output logic [COMMIT_W*32-1:0]   cmt_inst,
    output logic [COMMIT_W-1:0]      cmt_wen,
    output logic [COMMIT_W*8-1:0]    cmt_wdest,
    output logic [COMMIT_W*XLEN-1:0] cmt_wdata,
    output logic [COMMIT_W-1:0]      cmt_skip,
    output logic                     trap_valid,
    output logic [7:0]               trap_code,
    output logic [XLEN-1:0]          trap_pc,
    output logic [63:0]              cycle_cnt,
    output logic [63:0]              instr_cnt,
    output logic                     halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam int          c_cnt_w    = $clog2(COMMIT_W + 1);
    localparam bit          c_wd_en    = (TIMEOUT > 0);
    localparam logic [31:0] c_wd_limit = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [COMMIT_W-1:0]        r_cmt_valid;
    logic [COMMIT_W*XLEN-1:0]   r_cmt_pc;
    logic [COMMIT_W*32-1:0]     r_cmt_inst;
    logic [COMMIT_W-1:0]        r_cmt_wen;
    logic [COMMIT_W*8-1:0]      r_cmt_wdest;
    logic [COMMIT_W*XLEN-1:0]   r_cmt_wdata;
    logic [COMMIT_W-1:0]        r_cmt_skip;
    logic                       r_trap_valid;
    logic [7:0]                 r_trap_code;
    logic [XLEN-1:0]            r_trap_pc;
    logic [63:0]                r_cycle_cnt;
    logic [63:0]                r_instr_cnt;
    logic [31:0]                r_wdog;
    logic [XLEN-1:0]            r_last_pc;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [COMMIT_W-1:0]        w_is_trap;
    logic [COMMIT_W-1:0]        w_wdest_nz;
    logic [COMMIT_W-1:0]        w_acc;
    logic                       w_any_acc;
    logic [c_cnt_w-1:0]         w_acc_cnt;
    logic                       w_open;
    logic                       w_trap_hit;
    logic [XLEN-1:0]            w_trap_pc;
    logic [XLEN-1:0]            w_last_pc;
    logic                       w_wd_fire;

    logic [COMMIT_W*XLEN-1:0]   w_cmt_pc;
    logic [COMMIT_W*32-1:0]     w_cmt_inst;
    logic [COMMIT_W-1:0]        w_cmt_wen;
    logic [COMMIT_W*8-1:0]      w_cmt_wdest;
    logic [COMMIT_W*XLEN-1:0]   w_cmt_wdata;
    logic [COMMIT_W-1:0]        w_cmt_skip;

    // Only the low byte of a0 is reported as the trap code.
    logic                       w_unused;
    assign w_unused = &{1'b0, a0_data[XLEN-1:8]};

    // ------------------------------------------------------------------------
    // Per-channel decode and output shaping
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_ch
        assign w_is_trap[gi]  = (in_inst[gi*32 +: 7] == TRAP_OPCODE);
        assign w_wdest_nz[gi] = |in_wdest[gi*5 +: 5];

        assign w_cmt_pc[gi*XLEN +: XLEN]   = w_acc[gi] ? in_pc[gi*XLEN +: XLEN]    : '0;
        assign w_cmt_inst[gi*32 +: 32]     = w_acc[gi] ? in_inst[gi*32 +: 32]      : 32'd0;
        assign w_cmt_wdest[gi*8 +: 8]      = w_acc[gi] ? {3'b000, in_wdest[gi*5 +: 5]} : 8'd0;
        assign w_cmt_wdata[gi*XLEN +: XLEN] = w_acc[gi] ? in_wdata[gi*XLEN +: XLEN] : '0;
    end

    // Writes to x0 are architecturally dropped, so never report them.
    assign w_cmt_wen  = w_acc & in_wen & w_wdest_nz;
    assign w_cmt_skip = w_acc & in_skip;
    assign w_any_acc  = |w_acc;

    // ------------------------------------------------------------------------
    // Acceptance: a contiguous run of valid channels starting at channel 0.
    // The run ends at the first invalid channel or just after the first trap
    // instruction, so at most one trap can be accepted per cycle and it is
    // always the highest accepted channel.
    // ------------------------------------------------------------------------
    always_comb begin
        w_acc      = '0;
        w_acc_cnt  = '0;
        w_trap_hit = 1'b0;
        w_trap_pc  = '0;
        w_last_pc  = r_last_pc;
        w_open     = (r_state == ST_RUN);
        for (int i = 0; i < COMMIT_W; i++) begin
            if (w_open && in_valid[i]) begin
                w_acc[i]  = 1'b1;
                w_acc_cnt = w_acc_cnt + c_cnt_w'(1);
                w_last_pc = in_pc[i*XLEN +: XLEN];
                if (w_is_trap[i]) begin
                    w_trap_hit = 1'b1;
                    w_trap_pc  = in_pc[i*XLEN +: XLEN];
                    w_open     = 1'b0;
                end
            end else begin
                w_open = 1'b0;
            end
        end
    end

    // The watchdog fires on the idle edge that would take the counter past
    // TIMEOUT-1, i.e. the TIMEOUT-th consecutive edge without a commit.
    assign w_wd_fire = c_wd_en && (r_state == ST_RUN) && !w_any_acc &&
                       (r_wdog == c_wd_limit);

    // ------------------------------------------------------------------------
    // Run/halt state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_trap_hit || w_wd_fire) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers. While halted w_acc is all zero, so the commit
    // bundle clears itself without a separate halted branch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmt_valid  <= '0;
            r_cmt_pc     <= '0;
            r_cmt_inst   <= '0;
            r_cmt_wen    <= '0;
            r_cmt_wdest  <= '0;
            r_cmt_wdata  <= '0;
            r_cmt_skip   <= '0;
            r_trap_valid <= 1'b0;
            r_trap_code  <= 8'd0;
            r_trap_pc    <= '0;
            r_cycle_cnt  <= 64'd0;
            r_instr_cnt  <= 64'd0;
            r_wdog       <= 32'd0;
            r_last_pc    <= '0;
        end else begin
            r_cmt_valid <= w_acc;
            r_cmt_pc    <= w_cmt_pc;
            r_cmt_inst  <= w_cmt_inst;
            r_cmt_wen   <= w_cmt_wen;
            r_cmt_wdest <= w_cmt_wdest;
            r_cmt_wdata <= w_cmt_wdata;
            r_cmt_skip  <= w_cmt_skip;

            if (r_state == ST_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
                r_instr_cnt <= r_instr_cnt + 64'(w_acc_cnt);

                if (w_any_acc) begin
                    r_wdog    <= 32'd0;
                    r_last_pc <= w_last_pc;
                end else if (c_wd_en && !w_wd_fire) begin
                    r_wdog <= r_wdog + 32'd1;
                end

                // An instruction trap takes priority over the watchdog.
                if (w_trap_hit) begin
                    r_trap_valid <= 1'b1;
                    r_trap_code  <= a0_data[7:0];
                    r_trap_pc    <= w_trap_pc;
                end else if (w_wd_fire) begin
                    r_trap_valid <= 1'b1;
                    r_trap_code  <= TIMEOUT_CODE;
                    r_trap_pc    <= r_last_pc;
                end
            end
        end
    end

    assign cmt_valid  = r_cmt_valid;
    assign cmt_pc     = r_cmt_pc;
    assign cmt_inst   = r_cmt_inst;
    assign cmt_wen    = r_cmt_wen;
    assign cmt_wdest  = r_cmt_wdest;
    assign cmt_wdata  = r_cmt_wdata;
    assign cmt_skip   = r_cmt_skip;
    assign trap_valid = r_trap_valid;
    assign trap_code  = r_trap_code;
    assign trap_pc    = r_trap_pc;
    assign cycle_cnt  = r_cycle_cnt;
    assign instr_cnt  = r_instr_cnt;
    assign halted     = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_diff_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_diff_commit_unit
// Purpose  : Self-checking bench for diff_commit_unit (2 channels, XLEN 64,
//            watchdog TIMEOUT 8). A behavioural model predicts each edge.
//            Its prediction is queued and compared once the DUT has
//            registered that edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diff_commit_unit;

    localparam int c_to = 8;

    logic         clk;
    logic         rst;
    logic [1:0]   in_valid;
    logic [127:0] in_pc;
    logic [63:0]  in_inst;
    logic [1:0]   in_wen;
    logic [9:0]   in_wdest;
    logic [127:0] in_wdata;
    logic [1:0]   in_skip;
    logic [63:0]  a0_data;

    logic [1:0]   cmt_valid;
    logic [127:0] cmt_pc;
    logic [63:0]  cmt_inst;
    logic [1:0]   cmt_wen;
    logic [15:0]  cmt_wdest;
    logic [127:0] cmt_wdata;
    logic [1:0]   cmt_skip;
    logic         trap_valid;
    logic [7:0]   trap_code;
    logic [63:0]  trap_pc;
    logic [63:0]  cycle_cnt;
    logic [63:0]  instr_cnt;
    logic         halted;

    diff_commit_unit #(
        .COMMIT_W     (2),
        .XLEN         (64),
        .TRAP_OPCODE  (7'h6b),
        .TIMEOUT      (c_to),
        .TIMEOUT_CODE (8'hFF)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_wen     (in_wen),
        .in_wdest   (in_wdest),
        .in_wdata   (in_wdata),
        .in_skip    (in_skip),
        .a0_data    (a0_data),
        .cmt_valid  (cmt_valid),
        .cmt_pc     (cmt_pc),
        .cmt_inst   (cmt_inst),
        .cmt_wen    (cmt_wen),
        .cmt_wdest  (cmt_wdest),
        .cmt_wdata  (cmt_wdata),
        .cmt_skip   (cmt_skip),
        .trap_valid (trap_valid),
        .trap_code  (trap_code),
        .trap_pc    (trap_pc),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   valid;
        logic [127:0] pc;
        logic [63:0]  inst;
        logic [1:0]   wen;
        logic [15:0]  wdest;
        logic [127:0] wdata;
        logic [1:0]   skip;
        logic         tv;
        logic [7:0]   tc;
        logic [63:0]  tpc;
        logic [63:0]  cyc;
        logic [63:0]  ins;
        logic         halted;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state
    bit          m_halted;
    bit          m_tv;
    logic [7:0]  m_tc;
    logic [63:0] m_tpc;
    logic [63:0] m_cyc;
    logic [63:0] m_ins;
    int          m_wdog;
    logic [63:0] m_last_pc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Predict the DUT state after the coming edge from the current inputs.
    task automatic predict();
        exp_t e;
        int   n;
        int   tch;
        bit   t0;
        bit   t1;
        e = '0;
        if (rst) begin
            m_halted  = 1'b0;
            m_tv      = 1'b0;
            m_tc      = 8'd0;
            m_tpc     = 64'd0;
            m_cyc     = 64'd0;
            m_ins     = 64'd0;
            m_wdog    = 0;
            m_last_pc = 64'd0;
        end else if (!m_halted) begin
            t0 = (in_inst[6:0] == 7'h6b);
            t1 = (in_inst[38:32] == 7'h6b);
            if (!in_valid[0])              n = 0;
            else if (!in_valid[1] || t0)   n = 1;
            else                           n = 2;
            tch = -1;
            if (n >= 1 && t0)      tch = 0;
            else if (n == 2 && t1) tch = 1;
            for (int c = 0; c < n; c++) begin
                e.valid[c]          = 1'b1;
                e.pc[c*64 +: 64]    = in_pc[c*64 +: 64];
                e.inst[c*32 +: 32]  = in_inst[c*32 +: 32];
                e.wen[c]            = in_wen[c] && (in_wdest[c*5 +: 5] != 5'd0);
                e.wdest[c*8 +: 8]   = {3'b000, in_wdest[c*5 +: 5]};
                e.wdata[c*64 +: 64] = in_wdata[c*64 +: 64];
                e.skip[c]           = in_skip[c];
            end
            m_cyc = m_cyc + 64'd1;
            m_ins = m_ins + 64'(n);
            if (tch >= 0) begin
                m_halted = 1'b1;
                m_tv     = 1'b1;
                m_tc     = a0_data[7:0];
                m_tpc    = in_pc[tch*64 +: 64];
            end else if (n == 0 && m_wdog == c_to - 1) begin
                m_halted = 1'b1;
                m_tv     = 1'b1;
                m_tc     = 8'hFF;
                m_tpc    = m_last_pc;
            end
            if (n > 0) begin
                m_wdog    = 0;
                m_last_pc = in_pc[(n-1)*64 +: 64];
            end else if (!m_halted) begin
                m_wdog++;
            end
        end
        e.tv     = m_tv;
        e.tc     = m_tc;
        e.tpc    = m_tpc;
        e.cyc    = m_cyc;
        e.ins    = m_ins;
        e.halted = m_halted;
        q_exp.push_back(e);
    endtask

    // One clock: queue the prediction, let the edge happen, compare.
    task automatic step();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            e = q_exp.pop_front();
            check("cmt_valid",  cmt_valid,  e.valid);
            check("cmt_pc",     cmt_pc,     e.pc);
            check("cmt_inst",   cmt_inst,   e.inst);
            check("cmt_wen",    cmt_wen,    e.wen);
            check("cmt_wdest",  cmt_wdest,  e.wdest);
            check("cmt_wdata",  cmt_wdata,  e.wdata);
            check("cmt_skip",   cmt_skip,   e.skip);
            check("trap_valid", trap_valid, e.tv);
            check("trap_code",  trap_code,  e.tc);
            check("trap_pc",    trap_pc,    e.tpc);
            check("cycle_cnt",  cycle_cnt,  e.cyc);
            check("instr_cnt",  instr_cnt,  e.ins);
            check("halted",     halted,     e.halted);
        end
    endtask

    task automatic idle();
        in_valid = '0;
        in_pc    = '0;
        in_inst  = '0;
        in_wen   = '0;
        in_wdest = '0;
        in_wdata = '0;
        in_skip  = '0;
    endtask

    task automatic drive_ch(input int c, input logic [63:0] pc, input logic [31:0] inst,
                            input logic wen, input logic [4:0] wd, input logic [63:0] wdat,
                            input logic skip);
        in_valid[c]          = 1'b1;
        in_pc[c*64 +: 64]    = pc;
        in_inst[c*32 +: 32]  = inst;
        in_wen[c]            = wen;
        in_wdest[c*5 +: 5]   = wd;
        in_wdata[c*64 +: 64] = wdat;
        in_skip[c]           = skip;
    endtask

    task automatic do_reset(input int cycles);
        idle();
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r_inst;
        rst     = 1'b0;
        a0_data = 64'd0;
        idle();
        @(negedge clk);

        // Reset and single commit
        do_reset(2);
        check("reset_halted", halted, 1'b0);
        drive_ch(0, 64'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b0);
        step();
        check("single_valid", cmt_valid, 2'b01);
        check("single_wdest", cmt_wdest[7:0], 8'd1);
        check("single_instr", instr_cnt, 64'd1);
        check("single_cycle", cycle_cnt, 64'd1);

        // Dual commit, channel 1 writes x0
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            idle();
            drive_ch(0, 64'h8000_0100 + 64'(k*8), 32'h0020_0113, 1'b1, 5'd2, 64'(k), 1'b0);
            drive_ch(1, 64'h8000_0104 + 64'(k*8), 32'h0000_0013, 1'b1, 5'd0, 64'hdead, 1'b1);
            step();
        end
        check("dual_instr", instr_cnt, 64'd6);
        check("dual_cycle", cycle_cnt, 64'd3);
        check("dual_wen1",  cmt_wen[1], 1'b0);

        // Gap: channel 1 alone is dropped
        idle();
        drive_ch(1, 64'h8000_0200, 32'h0000_0013, 1'b1, 5'd3, 64'd7, 1'b0);
        step();
        check("gap_valid", cmt_valid, 2'b00);
        check("gap_instr", instr_cnt, 64'd6);

        // Random traffic, occasional trap opcode
        do_reset(1);
        for (int k = 0; k < 40; k++) begin
            idle();
            a0_data = {$urandom, $urandom};
            for (int c = 0; c < 2; c++) begin
                r_inst = $urandom;
                r_inst[6:0] = ($urandom_range(0, 15) == 0) ? 7'h6b : 7'h13;
                drive_ch(c, {32'h8000_0000, $urandom}, r_inst, 1'($urandom),
                         5'($urandom), {$urandom, $urandom}, 1'($urandom));
            end
            in_valid = 2'($urandom);
            step();
        end

        // Trap in channel 0 with channel 1 valid
        do_reset(1);
        idle();
        drive_ch(0, 64'h8000_0300, 32'h0010_0093, 1'b1, 5'd1, 64'd5, 1'b0);
        step();
        idle();
        a0_data = 64'd0;
        drive_ch(0, 64'h8000_0304, 32'h0000_006b, 1'b0, 5'd0, 64'd0, 1'b0);
        drive_ch(1, 64'h8000_0308, 32'h0010_0093, 1'b1, 5'd1, 64'd9, 1'b0);
        step();
        check("trap0_valid", cmt_valid, 2'b01);
        check("trap0_tv",    trap_valid, 1'b1);
        check("trap0_code",  trap_code, 8'd0);
        check("trap0_pc",    trap_pc, 64'h8000_0304);
        idle();
        for (int k = 0; k < 10; k++) begin
            drive_ch(0, 64'h8000_0400 + 64'(k*4), 32'h0010_0093, 1'b1, 5'd1, 64'(k), 1'b0);
            drive_ch(1, 64'h8000_0500 + 64'(k*4), 32'h0010_0093, 1'b1, 5'd2, 64'(k), 1'b0);
            step();
        end
        check("frozen_valid", cmt_valid, 2'b00);
        check("frozen_cycle", cycle_cnt, 64'd2);
        check("frozen_instr", instr_cnt, 64'd2);

        // Reset while halted, then a single commit
        do_reset(1);
        check("rst_halted", halted, 1'b0);
        check("rst_tv",     trap_valid, 1'b0);
        drive_ch(0, 64'h8000_0008, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b0);
        step();
        check("rst_instr", instr_cnt, 64'd1);

        // Trap in channel 1, a0 low byte becomes the code
        do_reset(1);
        a0_data = 64'h1234;
        drive_ch(0, 64'h8000_0200, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b0);
        drive_ch(1, 64'h8000_0204, 32'h0000_006b, 1'b0, 5'd0, 64'd0, 1'b0);
        step();
        check("trap1_valid", cmt_valid, 2'b11);
        check("trap1_code",  trap_code, 8'h34);
        check("trap1_pc",    trap_pc, 64'h8000_0204);

        // Watchdog: one commit then 8 idle edges
        do_reset(1);
        drive_ch(0, 64'h8000_0010, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b0);
        step();
        idle();
        for (int k = 0; k < 7; k++) step();
        check("wd_7_tv", trap_valid, 1'b0);
        step();
        check("wd_8_tv",   trap_valid, 1'b1);
        check("wd_8_code", trap_code, 8'hFF);
        check("wd_8_pc",   trap_pc, 64'h8000_0010);
        check("wd_8_halt", halted, 1'b1);

        // Watchdog: commit on the 7th idle cycle prevents the trap
        do_reset(1);
        drive_ch(0, 64'h8000_0010, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b0);
        step();
        idle();
        for (int k = 0; k < 6; k++) step();
        drive_ch(0, 64'h8000_0020, 32'h0010_0093, 1'b1, 5'd1, 64'd2, 1'b0);
        step();
        idle();
        for (int k = 0; k < 7; k++) step();
        check("wd_saved_tv", trap_valid, 1'b0);
        step();
        check("wd_late_tv", trap_valid, 1'b1);
        check("wd_late_pc", trap_pc, 64'h8000_0020);

        // Watchdog from reset with no commit at all
        do_reset(1);
        for (int k = 0; k < 8; k++) step();
        check("wd_none_tv", trap_valid, 1'b1);
        check("wd_none_pc", trap_pc, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
